change_dispense_sequencer: RTL

Sequences the single shared coin-ejector mechanism to pay out the change amount computed by the vending controller. Uses greedy largest-denomination-first selection over three coin tubes and tracks per-tube stock counters. Drives the ejector with a req/ack handshake and an ack timeout. Sits between the vending controller's change output and the physical payout hardware; also accepts tube refills from the service interface.

---
 rtl/change_dispense_sequencer_if.sv | 10 +
 rtl/change_dispense_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/change_dispense_sequencer_if.sv
// Coin-ejector handshake: the sequencer requests one coin from a tube,
// and the ejector acknowledges once that coin has dropped.
interface change_dispense_sequencer_if;
   logic       eject_req;
   logic [1:0] eject_sel;
   logic       eject_ack;

   modport master (output eject_req, output eject_sel, input eject_ack);
   modport slave  (input eject_req, input eject_sel, output eject_ack);
endinterface

// File: rtl/change_dispense_sequencer.sv
// Pays out change one coin at a time, largest denomination first, over three
// coin tubes that share one ejector. Also keeps the per-tube stock counts.
module change_dispense_sequencer #(
   parameter int unsigned DENOM_A     = 10,
   parameter int unsigned DENOM_B     = 5,
   parameter int unsigned DENOM_C     = 1,
   parameter int unsigned INIT_STOCK  = 8,
   parameter int unsigned ACK_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] change_amt,
   input  logic       refill,
   input  logic [1:0] refill_sel,
   input  logic [7:0] refill_qty,
   output logic       busy,
   output logic       done,
   output logic       short,
   output logic       fault,
   output logic [7:0] remaining,
   output logic [7:0] stock_a,
   output logic [7:0] stock_b,
   output logic [7:0] stock_c,
   change_dispense_sequencer_if.master eject
);

   localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);
   localparam logic [7:0]  DEN_A = 8'(DENOM_A);
   localparam logic [7:0]  DEN_B = 8'(DENOM_B);
   localparam logic [7:0]  DEN_C = 8'(DENOM_C);

   typedef enum logic [1:0] {S_IDLE, S_SELECT, S_WAIT} state_t;

   state_t             state, state_d;
   logic [CNT_W-1:0]   cnt, cnt_d;
   logic               busy_d, done_d, short_d, fault_d, req_d;
   logic [1:0]         sel_d;
   logic [7:0]         rem_d, a_d, b_d, c_d;
   logic [7:0]         refill_base, refill_val, sel_denom;
   logic [8:0]         refill_sum;
   logic               elig_a, elig_b, elig_c;

   assign elig_a = (remaining >= DEN_A) && (stock_a != 8'd0);
   assign elig_b = (remaining >= DEN_B) && (stock_b != 8'd0);
   assign elig_c = (remaining >= DEN_C) && (stock_c != 8'd0);

   // Saturating refill value for whichever tube refill_sel names
   always_comb begin
      case (refill_sel)
         2'd0:    refill_base = stock_a;
         2'd1:    refill_base = stock_b;
         default: refill_base = stock_c;
      endcase
      refill_sum = {1'b0, refill_base} + {1'b0, refill_qty};
      refill_val = refill_sum[8] ? 8'hFF : refill_sum[7:0];
   end

   always_comb begin
      case (eject.eject_sel)
         2'd0:    sel_denom = DEN_A;
         2'd1:    sel_denom = DEN_B;
         default: sel_denom = DEN_C;
      endcase
   end

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      busy_d  = busy;
      done_d  = 1'b0;
      short_d = short;
      fault_d = fault;
      rem_d   = remaining;
      req_d   = eject.eject_req;
      sel_d   = eject.eject_sel;
      a_d     = stock_a;
      b_d     = stock_b;
      c_d     = stock_c;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               rem_d   = change_amt;
               busy_d  = 1'b1;
               short_d = 1'b0;
               fault_d = 1'b0;
               state_d = S_SELECT;
            end else if (refill) begin
               case (refill_sel)
                  2'd0:    a_d = refill_val;
                  2'd1:    b_d = refill_val;
                  2'd2:    c_d = refill_val;
                  default: ;
               endcase
            end
         end
         S_SELECT: begin
            // Greedy pick: first tube in A, B, C order that fits and has coins
            if (remaining == 8'd0) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else if (elig_a || elig_b || elig_c) begin
               sel_d   = elig_a ? 2'd0 : (elig_b ? 2'd1 : 2'd2);
               req_d   = 1'b1;
               cnt_d   = '0;
               state_d = S_WAIT;
            end else begin
               short_d = 1'b1;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (eject.eject_ack) begin
               req_d   = 1'b0;
               rem_d   = remaining - sel_denom;
               state_d = S_SELECT;
               case (eject.eject_sel)
                  2'd0:    a_d = stock_a - 8'd1;
                  2'd1:    b_d = stock_b - 8'd1;
                  default: c_d = stock_c - 8'd1;
               endcase
            end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
               req_d   = 1'b0;
               fault_d = 1'b1;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= S_IDLE;
         cnt             <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         short           <= 1'b0;
         fault           <= 1'b0;
         remaining       <= 8'd0;
         eject.eject_req <= 1'b0;
         eject.eject_sel <= 2'd0;
         stock_a         <= 8'(INIT_STOCK);
         stock_b         <= 8'(INIT_STOCK);
         stock_c         <= 8'(INIT_STOCK);
      end else begin
         state           <= state_d;
         cnt             <= cnt_d;
         busy            <= busy_d;
         done            <= done_d;
         short           <= short_d;
         fault           <= fault_d;
         remaining       <= rem_d;
         eject.eject_req <= req_d;
         eject.eject_sel <= sel_d;
         stock_a         <= a_d;
         stock_b         <= b_d;
         stock_c         <= c_d;
      end
   end

endmodule
